// File: rtl/c17_fault_pkg.sv
// Shared types and helpers for the C17 fault-injection pipeline.
// A fault names one net of the C17 network and how that net's value is overridden.
package c17_fault_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        SA0  = 2'b01,
        SA1  = 2'b10,
        FLIP = 2'b11
    } fault_mode_t;

    localparam logic [3:0] NET_G1 = 4'd0;
    localparam logic [3:0] NET_G2 = 4'd1;
    localparam logic [3:0] NET_G3 = 4'd2;
    localparam logic [3:0] NET_G4 = 4'd3;
    localparam logic [3:0] NET_G5 = 4'd4;
    localparam logic [3:0] NET_W1 = 4'd5;
    localparam logic [3:0] NET_W2 = 4'd6;
    localparam logic [3:0] NET_W3 = 4'd7;
    localparam logic [3:0] NET_W4 = 4'd8;
    localparam logic [3:0] NET_G6 = 4'd9;
    localparam logic [3:0] NET_G7 = 4'd10;

    typedef struct packed {
        logic [3:0]  net;
        fault_mode_t mode;
    } fault_cfg_t;

    function automatic logic apply_fault(input logic value, input fault_mode_t mode);
        case (mode)
            SA0:     return 1'b0;
            SA1:     return 1'b1;
            FLIP:    return ~value;
            default: return value;
        endcase
    endfunction

    // Mode that applies to a given net; net codes 11-15 never match, so they act as "no fault".
    function automatic fault_mode_t net_mode(input fault_cfg_t cfg, input logic [3:0] net);
        return (cfg.net == net) ? cfg.mode : NONE;
    endfunction

endpackage

// File: rtl/c17_fault_pipe_if.sv
// Valid/ready transaction bus of the C17 fault pipeline: input stream and result stream.
interface c17_fault_pipe_if #(
    parameter int CHANNELS = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [5*CHANNELS-1:0]   in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*CHANNELS-1:0]   out_golden;
    logic [2*CHANNELS-1:0]   out_faulty;
    logic [CHANNELS-1:0]     out_mismatch;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_golden, out_faulty, out_mismatch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_golden, out_faulty, out_mismatch
    );
endinterface

// File: rtl/c17_fault_chan.sv
// One C17 channel: golden and fault-injected copies, two register stages.
// Stage 1 holds w2/w3/w4 per copy plus the output-net fault modes; stage 2 holds G7/G6.
module c17_fault_chan
    import c17_fault_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv1,
    input  logic       adv2,
    input  logic [4:0] in_g,
    input  fault_cfg_t cfg,
    output logic [1:0] golden,
    output logic [1:0] faulty,
    output logic       mismatch
);

    logic [4:0]  fg;
    logic        gw1, gw2, gw3, gw4;
    logic        fw1, fw2, fw3, fw4;
    logic [2:0]  s1_g, s1_f;
    fault_mode_t s1_m6, s1_m7;
    logic        gg6, gg7, fg6, fg7;

    // Each faulted net is overridden before any of its fanout reads it.
    always_comb begin
        fg = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            fg[i] = apply_fault(in_g[i], net_mode(cfg, 4'(i)));
        end
        gw1 = ~(in_g[4] & in_g[1]);
        gw2 = ~(in_g[4] & in_g[0]);
        gw3 = ~(gw1 & in_g[3]);
        gw4 = ~(gw1 & in_g[2]);
        fw1 = apply_fault(~(fg[4] & fg[1]), net_mode(cfg, NET_W1));
        fw2 = apply_fault(~(fg[4] & fg[0]), net_mode(cfg, NET_W2));
        fw3 = apply_fault(~(fw1 & fg[3]), net_mode(cfg, NET_W3));
        fw4 = apply_fault(~(fw1 & fg[2]), net_mode(cfg, NET_W4));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_g  <= '0;
            s1_f  <= '0;
            s1_m6 <= NONE;
            s1_m7 <= NONE;
        end else if (adv1) begin
            s1_g  <= {gw4, gw3, gw2};
            s1_f  <= {fw4, fw3, fw2};
            s1_m6 <= net_mode(cfg, NET_G6);
            s1_m7 <= net_mode(cfg, NET_G7);
        end
    end

    always_comb begin
        gg6 = ~(s1_g[0] & s1_g[1]);
        gg7 = ~(s1_g[2] & s1_g[1]);
        fg6 = apply_fault(~(s1_f[0] & s1_f[1]), s1_m6);
        fg7 = apply_fault(~(s1_f[2] & s1_f[1]), s1_m7);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            golden   <= '0;
            faulty   <= '0;
            mismatch <= 1'b0;
        end else if (adv2) begin
            golden   <= {gg7, gg6};
            faulty   <= {fg7, fg6};
            mismatch <= ({gg7, gg6} != {fg7, fg6});
        end
    end

endmodule

// File: rtl/c17_fault_pipe.sv
// Pipelined array of C17 golden/faulty channel pairs with valid/ready flow control,
// per-channel fault configuration registers and a saturating mismatch counter.
module c17_fault_pipe
    import c17_fault_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    c17_fault_pipe_if.slave   bus,
    input  logic              cfg_we,
    input  logic [CHAN_W-1:0] cfg_chan,
    input  logic [3:0]        cfg_net,
    input  logic [1:0]        cfg_mode,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                  s1_valid;
    logic                  out_valid_q;
    logic                  adv1, adv2;
    logic                  fire_err;
    fault_cfg_t            cfg_q [CHANNELS];
    logic [2*CHANNELS-1:0] golden, faulty;
    logic [CHANNELS-1:0]   mismatch;

    assign adv2          = !out_valid_q || bus.out_ready;
    assign adv1          = !s1_valid || adv2;
    assign bus.in_ready  = adv1;
    assign bus.out_valid = out_valid_q;
    assign bus.out_golden   = golden;
    assign bus.out_faulty   = faulty;
    assign bus.out_mismatch = mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (adv1) s1_valid    <= bus.in_valid;
            if (adv2) out_valid_q <= s1_valid;
        end
    end

    // Channels read cfg_q combinationally at accept, so a same-cycle write lands after capture.
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (rst) begin
                cfg_q[c] <= '0;
            end else if (cfg_we && cfg_chan == CHAN_W'(c)) begin
                cfg_q[c] <= '{net: cfg_net, mode: fault_mode_t'(cfg_mode)};
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        c17_fault_chan u_chan (
            .clk      (clk),
            .rst      (rst),
            .adv1     (adv1),
            .adv2     (adv2),
            .in_g     (bus.in_data[5*c +: 5]),
            .cfg      (cfg_q[c]),
            .golden   (golden[2*c +: 2]),
            .faulty   (faulty[2*c +: 2]),
            .mismatch (mismatch[c])
        );
    end

    assign fire_err = out_valid_q && bus.out_ready && (|mismatch);

    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_count <= '0;
            err_sat   <= 1'b0;
        end else if (fire_err && err_count != CNT_MAX) begin
            err_count <= err_count + 1'b1;
            if (err_count == CNT_MAX - 1'b1) err_sat <= 1'b1;
        end
    end

endmodule

// File: tb/tb_c17_fault_pipe.sv
// Scoreboard bench for c17_fault_pipe: a 4-channel instance with a 3-bit counter and a
// 1-channel instance fed channel 0 of the same stream, checked against a net-by-net C17 model.
module tb_c17_fault_pipe;
    localparam int CH = 4;
    localparam int CW = 3;
    localparam logic [CW-1:0] CMAX = '1;

    typedef struct {
        logic [2*CH-1:0] gold;
        logic [2*CH-1:0] faul;
        logic [CH-1:0]   mis;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_chan = '0;
    logic [3:0]    cfg_net = '0;
    logic [1:0]    cfg_mode = '0;
    logic          err_clr = 1'b0;
    logic [CW-1:0] err_count;
    logic          err_sat;
    logic          one_we;
    logic [15:0]   one_count;
    logic          one_sat;

    c17_fault_pipe_if #(.CHANNELS(CH)) bus ();
    c17_fault_pipe_if #(.CHANNELS(1))  bus1 ();

    assign bus1.in_valid  = bus.in_valid;
    assign bus1.in_data   = bus.in_data[4:0];
    assign bus1.out_ready = bus.out_ready;
    assign one_we         = cfg_we && (cfg_chan == 2'd0);

    c17_fault_pipe #(.CHANNELS(CH), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_net(cfg_net), .cfg_mode(cfg_mode),
        .err_clr(err_clr), .err_count(err_count), .err_sat(err_sat)
    );

    c17_fault_pipe #(.CHANNELS(1), .CNT_W(16)) u_one (
        .clk(clk), .rst(rst), .bus(bus1),
        .cfg_we(one_we), .cfg_chan(1'b0), .cfg_net(cfg_net), .cfg_mode(cfg_mode),
        .err_clr(err_clr), .err_count(one_count), .err_sat(one_sat)
    );

    int   errors = 0;
    int   checks = 0;
    int   accepted = 0;
    logic bp_en = 1'b0;
    exp_t q[$];
    logic [3:0] m_net [CH];
    logic [1:0] m_mode [CH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Nets indexed 0-4 G1..G5, 5-8 w1..w4, 9 G6, 10 G7; fault modes 0 none, 1 sa0, 2 sa1, 3 flip.
    function automatic logic [1:0] c17_model(input logic [4:0] g, input logic [3:0] fnet,
                                             input logic [1:0] fmode);
        logic v [11];
        for (int n = 0; n < 11; n++) begin
            case (n)
                5:       v[n] = !(v[4] && v[1]);
                6:       v[n] = !(v[4] && v[0]);
                7:       v[n] = !(v[5] && v[3]);
                8:       v[n] = !(v[5] && v[2]);
                9:       v[n] = !(v[6] && v[7]);
                10:      v[n] = !(v[8] && v[7]);
                default: v[n] = g[n];
            endcase
            if (n == int'(fnet)) begin
                case (fmode)
                    2'd1:    v[n] = 1'b0;
                    2'd2:    v[n] = 1'b1;
                    2'd3:    v[n] = !v[n];
                    default: ;
                endcase
            end
        end
        return {v[10], v[9]};
    endfunction

    task automatic drive(input logic v, input logic [5*CH-1:0] d, input logic we,
                         input logic [1:0] ch, input logic [3:0] net, input logic [1:0] md,
                         input logic clr, input logic r);
        exp_t e;
        @(negedge clk);
        rst = r; bus.in_valid = v; bus.in_data = d;
        cfg_we = we; cfg_chan = ch; cfg_net = net; cfg_mode = md; err_clr = clr;
        #4;
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_net[c] = 4'hF; m_mode[c] = 2'd0;
            end
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                for (int c = 0; c < CH; c++) begin
                    e.gold[2*c +: 2] = c17_model(d[5*c +: 5], 4'hF, 2'd0);
                    e.faul[2*c +: 2] = c17_model(d[5*c +: 5], m_net[c], m_mode[c]);
                    e.mis[c]         = (e.gold[2*c +: 2] != e.faul[2*c +: 2]);
                end
                q.push_back(e);
                accepted++;
            end
            if (cfg_we) begin
                m_net[ch] = net; m_mode[ch] = md;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [4:0] g);
        drive(1'b1, {CH{g}}, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [3:0] net, input logic [1:0] md);
        drive(1'b0, '0, 1'b1, ch, net, md, 1'b0, 1'b0);
    endtask

    // Monitor: drives backpressure, pops and compares on each delivered result, tracks the counter.
    initial begin : monitor
        exp_t          e;
        logic [CW-1:0] mc = '0;
        logic          ms = 1'b0;
        logic          fire;
        logic          prev_rst = 1'b1;
        logic          prev_stall = 1'b0;
        logic [2*CH-1:0] h_gold, h_faul;
        logic [CH-1:0]   h_mis;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus.out_ready = bp_en ? ($urandom_range(0, 99) >= 40) : 1'b1;
            #4;
            if (rst) begin
                q.delete();
                mc = '0; ms = 1'b0; prev_rst = 1'b1; prev_stall = 1'b0;
            end else begin
                fire = 1'b0;
                check("err_count", 64'(err_count), 64'(mc));
                check("err_sat", 64'(err_sat), 64'(ms));
                check("one_in_ready", 64'(bus1.in_ready), 64'(bus.in_ready));
                check("one_out_valid", 64'(bus1.out_valid), 64'(bus.out_valid));
                if (prev_rst) begin
                    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
                    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
                    check("rst_outputs", 64'({bus.out_golden, bus.out_faulty, bus.out_mismatch}), 64'(0));
                end
                if (prev_stall) begin
                    check("stall_valid", 64'(bus.out_valid), 64'(1));
                    check("stall_hold", 64'({bus.out_golden, bus.out_faulty, bus.out_mismatch}),
                          64'({h_gold, h_faul, h_mis}));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        check("spurious_output", 64'(1), 64'(0));
                    end else begin
                        e = q.pop_front();
                        check("golden", 64'(bus.out_golden), 64'(e.gold));
                        check("faulty", 64'(bus.out_faulty), 64'(e.faul));
                        check("mismatch", 64'(bus.out_mismatch), 64'(e.mis));
                        check("one_golden", 64'(bus1.out_golden), 64'(e.gold[1:0]));
                        check("one_faulty", 64'(bus1.out_faulty), 64'(e.faul[1:0]));
                        check("one_mismatch", 64'(bus1.out_mismatch), 64'(e.mis[0]));
                        fire = |e.mis;
                    end
                end
                if (err_clr) begin
                    mc = '0; ms = 1'b0;
                end else if (fire && mc != CMAX) begin
                    mc = mc + 1'b1;
                    if (mc == CMAX) ms = 1'b1;
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                h_gold = bus.out_golden; h_faul = bus.out_faulty; h_mis = bus.out_mismatch;
                prev_rst = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int acc0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        drive(1'b0, '0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b1);
        idle(2);

        // Fault-free, then w1 stuck-at-1 / stuck-at-0 on channel 0.
        send(5'b11111); idle(3);
        cfg(2'd0, 4'd5, 2'd2); send(5'b11111); idle(3);
        cfg(2'd0, 4'd5, 2'd1); send(5'b11111); idle(3);

        // G6 flip; the accept-cycle config write must only affect the following transaction.
        cfg(2'd0, 4'd9, 2'd3); send(5'b00000);
        drive(1'b1, '0, 1'b1, 2'd0, 4'd15, 2'd0, 1'b0, 1'b0);
        send(5'b00000); idle(3);

        // Saturate the 3-bit counter, then clear it on a cycle that also delivers a mismatch.
        cfg(2'd0, 4'd5, 2'd2);
        for (int i = 0; i < 9; i++) send(5'b11111);
        idle(4);
        send(5'b11111); send(5'b11111);
        drive(1'b1, {CH{5'b11111}}, 1'b0, 2'd0, 4'd0, 2'd0, 1'b1, 1'b0);
        idle(4);

        // Reset with two transactions in flight; the configured fault must be gone afterwards.
        send(5'b11111); send(5'b11111);
        drive(1'b0, '0, 1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 1'b1);
        send(5'b11111); idle(3);

        // Random traffic with backpressure, config writes and occasional clears.
        bp_en = 1'b1;
        acc0 = accepted;
        for (int cyc = 0; cyc < 20000 && accepted < acc0 + 1000; cyc++) begin
            drive($urandom_range(0, 99) < 70, (5*CH)'($urandom()),
                  $urandom_range(0, 99) < 10, 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 2, 1'b0);
        end
        check("random_progress", 64'(accepted - acc0 >= 1000), 64'(1));

        bp_en = 1'b0;
        for (int i = 0; i < 50 && q.size() > 0; i++) idle(1);
        idle(2);
        check("drain_empty", 64'(q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
